multiplier_seq_cla: RTL and testbench
=====================================

// Module: multiplier_seq_cla
// PURPOSE
//  Iterative shift-add multiplier: BITS_PER_CYCLE partial products per clock, summed by CLA adders.
//  Sequential, area-reduced successor of the combinational array multiplier. Used in datapaths
//  that tolerate multi-cycle latency. Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  MULTICAND_WID   32  width of multicand operand (>=2)
//  MULTIPLIER_WID  32  width of multiplier operand (>=2)
//  BITS_PER_CYCLE   1  multiplier bits retired per CALC cycle; must divide MULTIPLIER_WID
//                      (elaboration $error otherwise)
//  Derived: STEPS = MULTIPLIER_WID/BITS_PER_CYCLE; PWID = MULTICAND_WID+MULTIPLIER_WID
// PORTS
//  clk          in   1               single clock, rising edge
//  rst_n        in   1               asynchronous, active-low reset
//  in_valid     in   1               operands valid
//  in_ready     out  1               block can accept operands
//  multicand    in   MULTICAND_WID   operand A
//  multiplier   in   MULTIPLIER_WID  operand B
//  out_valid    out  1               product valid
//  out_ready    in   1               consumer accepts product
//  product      out  PWID            A*B; held stable while out_valid=1
//  signed_mode  in   1               only with SIGNED_MULT_EN; sampled with operands
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, product=0, count=0,
//   internal accumulator/operand regs=0. Reset mid-operation aborts; no output produced.
//  FSM IDLE/CALC/DONE:
//   IDLE: in_ready=1. in_valid&in_ready -> latch A, B; acc=0; count=0; -> CALC.
//   CALC: in_ready=0. Each cycle: acc_hi += sum_{k<BPC} (A & {B[k]}) << k via CLA chain;
//         {acc} shifts right BPC; B shifts right BPC; count++.
//         count==STEPS-1 -> DONE, product loaded from final acc on that edge.
//   DONE: out_valid=1, in_ready=0. out_ready=1 -> out_valid=0, -> IDLE.
//         out_ready=0 -> hold product and out_valid indefinitely.
//  Latency: acceptance edge to out_valid high = exactly STEPS cycles. Throughput: one op per
//   STEPS+2 cycles min (no overlap; in_ready stays low in DONE).
//  out_ready high in IDLE/CALC is ignored. in_valid in CALC/DONE is ignored (not consumed).
//  Arithmetic: unsigned default; full PWID-bit result, never truncated or saturated.
//   Max case A=B=all-ones -> (2^MA-1)*(2^MB-1) exact. Zero operands take full STEPS cycles.
//  count width = $clog2(STEPS)+1; no wrap within an operation.
// CONFIGURATION
//  `define SIGNED_MULT_EN: adds signed_mode port. signed_mode=1 at acceptance: operands are
//   two's complement; block latches sign=A[MSB]^B[MSB], iterates on magnitudes (most negative
//   value -> 2^(W-1), representable unsigned), negates result on the CALC->DONE edge.
//   Latency unchanged. signed_mode=0 -> unsigned, identical to macro-off behaviour.
//  Macro undefined: no signed_mode port; all operands unsigned.
// TESTING (MULTICAND_WID=MULTIPLIER_WID=8, BITS_PER_CYCLE=2 unless noted)
//  1 Reset: rst_n=0 mid-CALC -> out_valid=0, in_ready=1, product=0 immediately (async).
//  2 A=8'hFF, B=8'hFF, in_valid 1 cycle -> out_valid exactly 4 cycles after accept,
//    product=16'hFE01.
//  3 A=8'd13, B=8'd0 -> product=16'h0000 after 4 cycles; in_ready=0 through CALC and DONE.
//  4 Backpressure: A=8'd7, B=8'd9, out_ready=0 for 10 cycles -> product=16'd63 held, out_valid
//    held; in_valid pulses during hold not accepted; out_ready=1 -> IDLE next cycle.
//  5 BITS_PER_CYCLE=1, A=8'hA5, B=8'h3C -> out_valid 8 cycles after accept, product=16'h26AC;
//    back-to-back second op A=1,B=1 -> product=16'h0001.
//  6 SIGNED_MULT_EN, signed_mode=1: A=8'h80 (-128), B=8'hFF (-1) -> product=16'h0080;
//    A=8'h80, B=8'h7F -> product=16'hC080.

Source files
------------

// File: rtl/multiplier_seq_cla.sv
// Iterative shift-add multiplier: BITS_PER_CYCLE partial products per clock,
// accumulated through carry-lookahead (parallel-prefix) adders.
// Optional feature macro: SIGNED_MULT_EN (adds signed_mode port, two's complement operands).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | retiring BITS_PER_CYCLE multiplier bits per cycle
// DONE  | product valid, waiting for out_ready
module multiplier_seq_cla #(
    parameter int MULTICAND_WID  = 32,
    parameter int MULTIPLIER_WID = 32,
    parameter int BITS_PER_CYCLE = 1,
    localparam int STEPS = MULTIPLIER_WID / BITS_PER_CYCLE,
    localparam int PWID  = MULTICAND_WID + MULTIPLIER_WID
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MULTICAND_WID-1:0]  multicand,
    input  logic [MULTIPLIER_WID-1:0] multiplier,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PWID-1:0]           product
`ifdef SIGNED_MULT_EN
    ,
    input  logic                      signed_mode
`endif
);

    localparam int CW  = $clog2(STEPS) + 1;
    localparam int SW  = MULTICAND_WID + BITS_PER_CYCLE;
    localparam int BPC = BITS_PER_CYCLE;

    if (MULTIPLIER_WID % BITS_PER_CYCLE != 0) begin : g_bpc_check
        $error("BITS_PER_CYCLE must divide MULTIPLIER_WID");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state;
    logic [MULTICAND_WID-1:0]  a_reg;
    logic [MULTIPLIER_WID-1:0] b_reg;
    logic [PWID-1:0]           acc;
    logic [CW-1:0]             count;

    logic [MULTICAND_WID-1:0]  a_in;
    logic [MULTIPLIER_WID-1:0] b_in;
    logic [SW-1:0]             sum;
    logic [PWID-1:0]           acc_nx;
    logic [PWID-1:0]           fin_prod;

`ifdef SIGNED_MULT_EN
    logic sign_reg;
`endif

    // Kogge-Stone style carry lookahead; sums never overflow SW bits here.
    function automatic logic [SW-1:0] cla_add(input logic [SW-1:0] x, input logic [SW-1:0] y);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW-1:0] gg;
        logic [SW-1:0] pp;
        g  = x & y;
        p  = x ^ y;
        gg = g;
        pp = p;
        for (int d = 1; d < SW; d = d * 2) begin
            for (int i = SW - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        return p ^ {gg[SW-2:0], 1'b0};
    endfunction

    // Operand conditioning: magnitudes in signed mode, pass-through otherwise.
    always_comb begin
`ifdef SIGNED_MULT_EN
        a_in = (signed_mode && multicand[MULTICAND_WID-1])  ? (~multicand + 1'b1)  : multicand;
        b_in = (signed_mode && multiplier[MULTIPLIER_WID-1]) ? (~multiplier + 1'b1) : multiplier;
`else
        a_in = multicand;
        b_in = multiplier;
`endif
    end

    // One CALC step: add BPC shifted partial products into the upper accumulator, shift right.
    always_comb begin
        sum = {{BPC{1'b0}}, acc[PWID-1:MULTIPLIER_WID]};
        for (int k = 0; k < BPC; k++) begin
            sum = cla_add(sum, b_reg[k] ? ({{BPC{1'b0}}, a_reg} << k) : '0);
        end
        acc_nx = PWID'({sum, acc[MULTIPLIER_WID-1:0]} >> BPC);
`ifdef SIGNED_MULT_EN
        fin_prod = sign_reg ? (~acc_nx + 1'b1) : acc_nx;
`else
        fin_prod = acc_nx;
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            count     <= '0;
            acc       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
`ifdef SIGNED_MULT_EN
            sign_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a_in;
                        b_reg    <= b_in;
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
`ifdef SIGNED_MULT_EN
                        sign_reg <= signed_mode &
                                    (multicand[MULTICAND_WID-1] ^ multiplier[MULTIPLIER_WID-1]);
`endif
                    end
                end
                CALC: begin
                    acc   <= acc_nx;
                    b_reg <= b_reg >> BPC;
                    count <= count + 1'b1;
                    if (count == CW'(STEPS - 1)) begin
                        product   <= fin_prod;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq_cla.sv
// Bench for multiplier_seq_cla: two 8x8 instances (2 and 1 bits per cycle),
// directed corner cases plus random operands against an arithmetic reference.
module tb_multiplier_seq_cla;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_v  [2];
    logic        in_ready_v  [2];
    logic        out_valid_v [2];
    logic        out_ready_v [2];
    logic [7:0]  a_v         [2];
    logic [7:0]  b_v         [2];
    logic [15:0] product_v   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiplier_seq_cla #(.MULTICAND_WID(8), .MULTIPLIER_WID(8), .BITS_PER_CYCLE(2)) u_dut_bpc2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .multicand(a_v[0]), .multiplier(b_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .product(product_v[0])
    );

    multiplier_seq_cla #(.MULTICAND_WID(8), .MULTIPLIER_WID(8), .BITS_PER_CYCLE(1)) u_dut_bpc1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .multicand(a_v[1]), .multiplier(b_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .product(product_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, check latency/result, optional stall, release.
    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input int stall, input bit noise);
        int          steps;
        int          cyc;
        logic [15:0] exp_p;
        steps = (sel == 0) ? 4 : 8;
        exp_p = 16'(32'(a) * 32'(b));
        cyc = 0;
        while (!in_ready_v[sel] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("in_ready_idle", 32'(in_ready_v[sel]), 32'd1);
        a_v[sel]         = a;
        b_v[sel]         = b;
        in_valid_v[sel]  = 1'b1;
        out_ready_v[sel] = noise;
        @(posedge clk); #1;
        in_valid_v[sel] = noise;
        if (noise) begin
            a_v[sel] = 8'($urandom);
            b_v[sel] = 8'($urandom);
        end
        cyc = 0;
        do begin
            chk("in_ready_calc", 32'(in_ready_v[sel]), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid_v[sel] && cyc < steps + 6);
        chk("latency", 32'(cyc), 32'(steps));
        chk("product", 32'(product_v[sel]), 32'(exp_p));
        in_valid_v[sel]  = 1'b0;
        out_ready_v[sel] = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            in_valid_v[sel] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid_v[sel]), 32'd1);
            chk("hold_product", 32'(product_v[sel]), 32'(exp_p));
            chk("in_ready_done", 32'(in_ready_v[sel]), 32'd0);
        end
        in_valid_v[sel]  = 1'b0;
        out_ready_v[sel] = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 32'(out_valid_v[sel]), 32'd0);
        chk("release_ready", 32'(in_ready_v[sel]), 32'd1);
        out_ready_v[sel] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid_v[s]  = 1'b0;
            out_ready_v[s] = 1'b0;
            a_v[s]         = '0;
            b_v[s]         = '0;
        end
        #12;
        chk("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
        chk("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
        chk("rst_product", 32'(product_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Max operands, zero operand, backpressure with ignored in_valid pulses.
        run_op(0, 8'hFF, 8'hFF, 0, 1'b0);
        run_op(0, 8'd13, 8'd0, 2, 1'b0);
        run_op(0, 8'd7, 8'd9, 10, 1'b0);

        // Async reset mid-CALC aborts and clears outputs immediately.
        run_op(0, 8'hFF, 8'hFF, 0, 1'b0);
        a_v[0] = 8'd3; b_v[0] = 8'd5; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid_v[0]), 32'd0);
        chk("abort_in_ready", 32'(in_ready_v[0]), 32'd1);
        chk("abort_product", 32'(product_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 8'd3, 8'd5, 1, 1'b0);

        // One bit per cycle, back-to-back operations.
        run_op(1, 8'hA5, 8'h3C, 0, 1'b0);
        run_op(1, 8'd1, 8'd1, 0, 1'b0);
        run_op(1, 8'hFF, 8'hFF, 1, 1'b1);
        run_op(1, 8'd0, 8'hFF, 0, 1'b0);

        // Random operands, stalls and ignored CALC-time input activity.
        for (int n = 0; n < 30; n++) begin
            for (int s = 0; s < 2; s++) begin
                run_op(s, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
